// File: rtl/data_mem_ctrl_pkg.sv
// Shared state/size encodings and default address map for the data-memory controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_BUF = 2'd1,
        READ   = 2'd2,
        WRITE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] DEF_LED_ADDR  = 32'h0000_2000;

    // Size field of sign_mask[2:1]; the unused code 10 behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage to data-memory bus: request side from the core, response side back to it.
interface data_mem_ctrl_if #(parameter int ADDR_W = 32);

    logic [ADDR_W-1:0] addr;
    logic [31:0]       write_data;
    logic              memwrite;
    logic              memread;
    logic [3:0]        sign_mask;
    logic [31:0]       read_data;
    logic              clk_stall;
    logic              misalign_err;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall, misalign_err
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall, misalign_err
    );

endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational lane extract (loads) and lane merge (stores) for a 32-bit word.
module dmem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] word_buf,
    input  logic [31:0] write_data_buf,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        sign,
    output logic [31:0] load_word,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = word_buf[{offset, 3'b000} +: 8];
        half_lane  = offset[1] ? word_buf[31:16] : word_buf[15:0];
        load_word  = word_buf;
        store_word = write_data_buf;
        case (size)
            SZ_BYTE: begin
                load_word  = {{24{sign & byte_lane[7]}}, byte_lane};
                store_word = word_buf;
                store_word[{offset, 3'b000} +: 8] = write_data_buf[7:0];
            end
            SZ_HALF: begin
                // offset[0] is dropped: halves always land on their aligned lane
                load_word  = {{16{sign & half_lane[15]}}, half_lane};
                store_word = word_buf;
                store_word[{offset[1], 4'b0000} +: 16] = write_data_buf[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word BRAM with byte/half/word access plus a memory-mapped LED register.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
//
// state  | meaning
// IDLE   | sample request inputs every cycle; start on memread|memwrite
// RD_BUF | fetch the addressed RAM word into word_buf
// READ   | update read_data with the extracted lane (or LED value)
// WRITE  | commit the merged word to RAM (or led_reg)
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
    parameter int          LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_ctrl_if.slave   bus,
    output logic [LED_W-1:0] led
);

    localparam int                IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LED_A = ADDR_W'(LED_ADDR);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] addr_buf;
    logic [31:0]       wdata_buf;
    logic [31:0]       word_buf;
    logic [3:1]        mask_buf;
    logic              load_buf;
    logic              stall_r;
    logic [31:0]       read_data_r;
    logic [LED_W-1:0]  led_reg;
    logic [31:0]       ram [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx;
    size_e             size;
    logic              is_led;
    logic              misaligned;
    logic              request;
    logic              ram_we;
    logic [31:0]       load_word;
    logic [31:0]       store_word;

    assign request = bus.memread | bus.memwrite;
    assign size    = decode_size(mask_buf[2:1]);
    assign is_led  = (addr_buf == LED_A);
    // Word index of (addr_buf - BASE), with the borrow out of the byte bits, modulo depth
    assign idx = addr_buf[IDX_W+1:2] - BASE[IDX_W+1:2]
               - IDX_W'(addr_buf[1:0] < BASE[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = !is_led
                      && ((size == SZ_HALF && addr_buf[0])
                      ||  (size == SZ_WORD && addr_buf[1:0] != 2'b00));
    assign bus.misalign_err = misaligned && (state == READ || state == WRITE);
`else
    assign misaligned       = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .word_buf       (word_buf),
        .write_data_buf (wdata_buf),
        .offset         (addr_buf[1:0]),
        .size           (size),
        .sign           (mask_buf[3]),
        .load_word      (load_word),
        .store_word     (store_word)
    );

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        case (state)
            IDLE:   if (request) state_nxt = RD_BUF;
            RD_BUF: state_nxt = load_buf ? READ : WRITE;
            READ:   state_nxt = IDLE;
            WRITE: begin
                state_nxt = IDLE;
                ram_we    = !is_led && !misaligned;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_buf    <= '0;
            wdata_buf   <= '0;
            word_buf    <= '0;
            mask_buf    <= '0;
            load_buf    <= 1'b0;
            stall_r     <= 1'b0;
            read_data_r <= '0;
            led_reg     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    addr_buf  <= bus.addr;
                    wdata_buf <= bus.write_data;
                    mask_buf  <= bus.sign_mask[3:1];
                    load_buf  <= bus.memread;
                    stall_r   <= request;
                end
                RD_BUF: word_buf <= ram[idx];
                READ: begin
                    stall_r <= 1'b0;
                    if (!misaligned)
                        read_data_r <= is_led ? 32'(led_reg) : load_word;
                end
                WRITE: begin
                    stall_r <= 1'b0;
                    if (is_led) led_reg <= wdata_buf[LED_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset; an abort before the WRITE edge leaves it untouched
    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= store_word;
    end

    assign bus.read_data = read_data_r;
    assign bus.clk_stall = stall_r;
    assign led           = led_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed spec cases plus randomized accesses vs a behavioural model.
module tb_data_mem_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led;

    data_mem_ctrl_if #(.ADDR_W(32)) bus ();

    data_mem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_m [1024];
    logic [7:0]  led_m = 8'h00;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_stall = 1'b0;
    logic        exp_err = 1'b0;
    int          stall_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [3:0] m);
        case (m[2:1])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [3:0] m);
        int unsigned n = size_of(m);
        int unsigned lane = ((a % 4) / n) * n;
        logic [31:0] low = (32'h1 << (8 * n)) - 1;
        logic [31:0] v;
        if (n == 4) return w;
        v = (w >> (8 * lane)) & low;
        if (m[3] && v[8*n-1]) v = v | ~low;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [31:0] a, input logic [3:0] m);
        int unsigned n = size_of(m);
        int unsigned lane = ((a % 4) / n) * n;
        logic [31:0] mask;
        if (n == 4) return wd;
        mask = ((32'h1 << (8 * n)) - 1) << (8 * lane);
        return (w & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    // Single compare process: all outputs checked every cycle, away from the edge.
    always @(posedge clk) begin
        #2;
        check("clk_stall", 32'(bus.clk_stall), 32'(exp_stall));
        check("misalign_err", 32'(bus.misalign_err), 32'(exp_err));
        check("read_data", bus.read_data, exp_rd);
        check("led", 32'(led), 32'(led_m));
        if (bus.clk_stall) stall_cnt++;
        if (bus.misalign_err) err_cnt++;
    end

    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input bit rd, input bit wr, input logic [3:0] m);
        bit          led_hit = (a == 32'h2000);
        int unsigned n = size_of(m);
        int unsigned idx = ((a - 32'h1000) >> 2) % 1024;
        bit          mis = TRAP && !led_hit && (a % n != 0);
        @(negedge clk);
        bus.addr = a;
        bus.write_data = wd;
        bus.sign_mask = m;
        bus.memread = rd;
        bus.memwrite = wr;
        @(posedge clk); #1;
        if (!(rd || wr)) return;
        exp_stall = 1'b1;
        // Junk while busy must be ignored
        bus.addr = $urandom;
        bus.write_data = $urandom;
        bus.sign_mask = 4'($urandom);
        bus.memread = 1'($urandom);
        bus.memwrite = 1'($urandom);
        @(posedge clk); #1;
        exp_err = mis;
        @(posedge clk); #1;
        exp_err = 1'b0;
        exp_stall = 1'b0;
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
        if (rd) begin
            if (led_hit) exp_rd = {24'h0, led_m};
            else if (!mis) exp_rd = model_load(mem_m[idx], a, m);
        end else begin
            if (led_hit) led_m = wd[7:0];
            else if (!mis) mem_m[idx] = model_store(mem_m[idx], wd, a, m);
        end
    endtask

    localparam logic [3:0] M_SW = 4'b0110, M_LW = 4'b1110, M_LWU = 4'b0110;
    localparam logic [3:0] M_SB = 4'b0000, M_LB = 4'b1000, M_LBU = 4'b0000;
    localparam logic [3:0] M_SH = 4'b0010, M_LH = 4'b1010, M_LHU = 4'b0010;

    initial begin
        logic [31:0] w0;
        logic [31:0] w3;
        bus.addr = '0;
        bus.write_data = '0;
        bus.sign_mask = '0;
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_read_data", bus.read_data, 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_stall", 32'(bus.clk_stall), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++)
            access(32'h1000 + 32'(i) * 4, $urandom, 1'b0, 1'b1, M_SW);

        // sw / lw with stall length
        stall_cnt = 0;
        access(32'h1004, 32'hDEADBEEF, 1'b0, 1'b1, M_SW);
        check("sw_stall_cycles", 32'(stall_cnt), 32'd2);
        access(32'h1004, 32'h0, 1'b1, 1'b0, M_LW);
        check("lw_deadbeef", bus.read_data, 32'hDEADBEEF);
        check("model_lw_deadbeef", exp_rd, 32'hDEADBEEF);

        // sb into the middle of a word
        access(32'h1004, 32'h11223344, 1'b0, 1'b1, M_SW);
        access(32'h1006, 32'h000000A5, 1'b0, 1'b1, M_SB);
        access(32'h1004, 32'h0, 1'b1, 1'b0, M_LWU);
        check("sb_merge", bus.read_data, 32'h11A53344);
        check("model_sb_merge", exp_rd, 32'h11A53344);
        access(32'h1006, 32'h0, 1'b1, 1'b0, M_LB);
        check("lb_sign", bus.read_data, 32'hFFFFFFA5);
        access(32'h1006, 32'h0, 1'b1, 1'b0, M_LBU);
        check("lbu_zero", bus.read_data, 32'h000000A5);

        // sh into the upper half
        access(32'h1008, 32'hCAFE1234, 1'b0, 1'b1, M_SW);
        access(32'h100A, 32'h00008001, 1'b0, 1'b1, M_SH);
        access(32'h100A, 32'h0, 1'b1, 1'b0, M_LH);
        check("lh_sign", bus.read_data, 32'hFFFF8001);
        check("model_lh_sign", exp_rd, 32'hFFFF8001);
        access(32'h100A, 32'h0, 1'b1, 1'b0, M_LHU);
        check("lhu_zero", bus.read_data, 32'h00008001);
        access(32'h1008, 32'h0, 1'b1, 1'b0, M_LW);
        check("sh_lower_kept", bus.read_data, 32'h80011234);

        // LED register; LED_ADDR aliases RAM word 0 but must not touch it
        access(32'h1000, 32'h0BADF00D, 1'b0, 1'b1, M_SW);
        access(32'h2000, 32'h0000005A, 1'b0, 1'b1, M_SW);
        check("led_store", 32'(led), 32'h5A);
        access(32'h1000, 32'h0, 1'b1, 1'b0, M_LW);
        check("led_ram_untouched", bus.read_data, 32'h0BADF00D);
        access(32'h2000, 32'h0, 1'b1, 1'b0, M_LB);
        check("led_load", bus.read_data, 32'h0000005A);

        // misaligned word store
        access(32'h1000, 32'h13579BDF, 1'b0, 1'b1, M_SW);
        err_cnt = 0;
        access(32'h1001, 32'h2468ACE0, 1'b0, 1'b1, M_SW);
        check("misalign_pulses", 32'(err_cnt), TRAP ? 32'd1 : 32'd0);
        access(32'h1000, 32'h0, 1'b1, 1'b0, M_LW);
        check("misalign_word0", bus.read_data, TRAP ? 32'h13579BDF : 32'h2468ACE0);

        // reset during RD_BUF of a store
        w3 = mem_m[3];
        @(negedge clk);
        bus.addr = 32'h100C;
        bus.write_data = ~w3;
        bus.sign_mask = M_SW;
        bus.memwrite = 1'b1;
        @(posedge clk); #1;
        bus.memwrite = 1'b0;
        exp_stall = 1'b1;
        rst_n = 1'b0;
        exp_stall = 1'b0;
        exp_rd = 32'h0;
        led_m = 8'h00;
        #1;
        check("reset_abort_stall", 32'(bus.clk_stall), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(32'h100C, 32'h0, 1'b1, 1'b0, M_LW);
        check("reset_abort_word", bus.read_data, w3);

        // randomized traffic, including aliases and the LED address
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            int unsigned op;
            a = 32'h1000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3))
              + 32'($urandom_range(0, 3)) * 32'h1000;
            if ($urandom_range(0, 9) == 0) a = 32'h2000;
            op = $urandom_range(0, 3);
            access(a, $urandom, op[0], op[1], 4'($urandom));
        end

        // every initialised word read back once more
        for (int i = 0; i < 64; i++)
            access(32'h1000 + 32'(i) * 4, 32'h0, 1'b1, 1'b0, M_LW);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
